// File: rtl/hsync.sv
// Horizontal timing generator: pixel-slot prescaler plus a SYNC/BACK/VISIBLE/FRONT
// line sequencer, with outputs decoded from registered state only.
module hsync #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  output logic       o_pen,
  output logic       o_hsync_en,
  output logic       o_addr_en,
  output logic [9:0] o_idx,
  output logic       o_ven
);

  localparam int unsigned PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAX_A = (H_SYNC > H_BACK) ? H_SYNC : H_BACK;
  localparam int unsigned MAX_B = (H_VISIBLE > H_FRONT) ? H_VISIBLE : H_FRONT;
  localparam int unsigned H_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned PHW   = (H_MAX > 1) ? $clog2(H_MAX) : 1;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    BACK    = 2'd1,
    VISIBLE = 2'd2,
    FRONT   = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  pre, pre_nxt;
  logic [PHW-1:0] phase, phase_nxt;
  logic [PHW-1:0] len_m1;
  logic           pen_c;
  logic           last_c;

  // Free-running pixel-slot prescaler; only reset clears it.
  always_comb begin
    pen_c   = (pre == PW'(CLK_DIV - 1));
    pre_nxt = pen_c ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      pre   <= '0;
      state <= SYNC;
      phase <= '0;
    end else begin
      pre   <= pre_nxt;
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Phase advances per pixel slot; the last slot of a region hands over to the next.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      SYNC:    len_m1 = PHW'(H_SYNC - 1);
      BACK:    len_m1 = PHW'(H_BACK - 1);
      VISIBLE: len_m1 = PHW'(H_VISIBLE - 1);
      FRONT:   len_m1 = PHW'(H_FRONT - 1);
      default: len_m1 = '0;
    endcase
    last_c = (phase == len_m1);
    if (pen_c) begin
      if (last_c) begin
        phase_nxt = '0;
        case (state)
          SYNC:    state_nxt = BACK;
          BACK:    state_nxt = VISIBLE;
          VISIBLE: state_nxt = FRONT;
          FRONT:   state_nxt = SYNC;
          default: state_nxt = SYNC;
        endcase
      end else begin
        phase_nxt = phase + PHW'(1);
      end
    end
  end

  assign o_pen      = pen_c;
  assign o_hsync_en = (state == SYNC);
  assign o_addr_en  = (state == VISIBLE);
  assign o_idx      = (state == VISIBLE) ? 10'(phase) : 10'd0;
  assign o_ven      = (state == FRONT) && last_c && pen_c;

endmodule
